// File: rtl/rv_idu_hs.sv
// RV32I/E instruction decode stage with a single-entry valid/ready output register.
// Holds the register file, reads operands at capture time (optional writeback forwarding)
// and keeps held operands up to date while the downstream stalls.
module rv_idu_hs #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NREG   = 32,
    parameter bit          BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [WIDTH-1:0] in_pc,
    input  logic             flush,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_imm,
    output logic [WIDTH-1:0] out_rs1_data,
    output logic [WIDTH-1:0] out_rs2_data,
    output logic [4:0]       out_rd,
    output logic             out_rf_we,
    output logic             out_is_load,
    output logic             out_is_store,
    output logic             out_is_branch,
    output logic             out_is_jump,
    output logic             out_ebreak,
    output logic             out_illegal
);

    localparam int unsigned AW       = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [5:0]  NREG_LIM = 6'(NREG);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    function automatic logic idx_ok(input logic [4:0] idx);
        return {1'b0, idx} < NREG_LIM;
    endfunction

    logic [WIDTH-1:0] rf_q [NREG];

    logic             valid_q;
    logic [WIDTH-1:0] pc_q, imm_q, rs1_data_q, rs2_data_q;
    logic [4:0]       rd_q, rs1_idx_q, rs2_idx_q;
    logic             rf_we_q, is_load_q, is_store_q, is_branch_q, is_jump_q;
    logic             ebreak_q, illegal_q;

    logic [6:0]       opcode;
    logic [4:0]       rd_idx, src1, src2;
    logic             op_known, use_rs1, use_rs2, use_rd;
    logic [31:0]      imm32;
    logic             dec_load, dec_store, dec_branch, dec_jump, dec_illegal, dec_rf_we;
    logic [4:0]       dec_rd;
    logic [WIDTH-1:0] dec_imm, rs1_rd, rs2_rd;
    logic             wb_write, capture;

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    // Only writes that really land in the array may forward or refresh.
    assign wb_write = wb_en && (wb_addr != 5'd0) && idx_ok(wb_addr);

    // Instruction decode: format, immediate, used registers and class flags.
    always_comb begin
        opcode     = in_inst[6:0];
        rd_idx     = in_inst[11:7];
        op_known   = 1'b1;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        use_rd     = 1'b0;
        imm32      = 32'd0;
        dec_load   = 1'b0;
        dec_store  = 1'b0;
        dec_branch = 1'b0;
        dec_jump   = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                use_rd = 1'b1;
                imm32  = {in_inst[31:12], 12'd0};
            end
            OP_JAL: begin
                use_rd   = 1'b1;
                dec_jump = 1'b1;
                imm32    = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                            in_inst[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: begin
                use_rd   = 1'b1;
                use_rs1  = 1'b1;
                dec_jump = (opcode == OP_JALR);
                dec_load = (opcode == OP_LOAD);
                imm32    = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OP_STORE: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                dec_store = 1'b1;
                imm32     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OP_BRANCH: begin
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                dec_branch = 1'b1;
                imm32      = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                              in_inst[11:8], 1'b0};
            end
            OP_OP: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: op_known = 1'b0;
        endcase
        // Unused source fields read as x0 so they never pick up data or refreshes.
        src1        = use_rs1 ? in_inst[19:15] : 5'd0;
        src2        = use_rs2 ? in_inst[24:20] : 5'd0;
        dec_illegal = !op_known || !idx_ok(src1) || !idx_ok(src2) ||
                      (use_rd && !idx_ok(rd_idx));
        dec_rf_we   = use_rd && (rd_idx != 5'd0) && !dec_illegal;
        dec_rd      = use_rd ? rd_idx : 5'd0;
        dec_imm     = WIDTH'($signed(imm32));
    end

    // Operand read with out-of-range indices returning 0 and optional forwarding.
    always_comb begin
        rs1_rd = '0;
        rs2_rd = '0;
        if (src1 != 5'd0 && idx_ok(src1)) rs1_rd = rf_q[src1[AW-1:0]];
        if (src2 != 5'd0 && idx_ok(src2)) rs2_rd = rf_q[src2[AW-1:0]];
        if (BYPASS) begin
            if (wb_write && wb_addr == src1) rs1_rd = wb_data;
            if (wb_write && wb_addr == src2) rs2_rd = wb_data;
        end
    end

    // Register file write port; reset clears every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wb_write) begin
            rf_q[wb_addr[AW-1:0]] <= wb_data;
        end
    end

    // Output register: reset, then flush, then capture, then drain, else hold and refresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            imm_q       <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            rd_q        <= '0;
            rs1_idx_q   <= '0;
            rs2_idx_q   <= '0;
            rf_we_q     <= 1'b0;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            is_branch_q <= 1'b0;
            is_jump_q   <= 1'b0;
            ebreak_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q     <= 1'b1;
            pc_q        <= in_pc;
            imm_q       <= dec_imm;
            rs1_data_q  <= rs1_rd;
            rs2_data_q  <= rs2_rd;
            rd_q        <= dec_rd;
            rs1_idx_q   <= src1;
            rs2_idx_q   <= src2;
            rf_we_q     <= dec_rf_we;
            is_load_q   <= dec_load;
            is_store_q  <= dec_store;
            is_branch_q <= dec_branch;
            is_jump_q   <= dec_jump;
            ebreak_q    <= (in_inst == 32'h0010_0073);
            illegal_q   <= dec_illegal;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end else if (valid_q) begin
            // Stalled: keep held operands coherent with the register file.
            if (wb_write && wb_addr == rs1_idx_q) rs1_data_q <= wb_data;
            if (wb_write && wb_addr == rs2_idx_q) rs2_data_q <= wb_data;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = pc_q;
    assign out_imm       = imm_q;
    assign out_rs1_data  = rs1_data_q;
    assign out_rs2_data  = rs2_data_q;
    assign out_rd        = rd_q;
    assign out_rf_we     = rf_we_q;
    assign out_is_load   = is_load_q;
    assign out_is_store  = is_store_q;
    assign out_is_branch = is_branch_q;
    assign out_is_jump   = is_jump_q;
    assign out_ebreak    = ebreak_q;
    assign out_illegal   = illegal_q;

endmodule

// File: tb/tb_rv_idu_hs.sv
// Directed bench for rv_idu_hs: default, no-bypass and RV32E instances share one stimulus.
module tb_rv_idu_hs;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, wb_en, out_ready;
    logic [31:0] in_inst, in_pc, wb_data;
    logic [4:0]  wb_addr;

    logic        a_in_ready, a_out_valid, a_rf_we, a_load, a_store, a_branch, a_jump;
    logic        a_ebreak, a_illegal;
    logic [31:0] a_pc, a_imm, a_rs1, a_rs2;
    logic [4:0]  a_rd;
    logic        b_in_ready, b_out_valid, b_rf_we, b_load, b_store, b_branch, b_jump;
    logic        b_ebreak, b_illegal;
    logic [31:0] b_pc, b_imm, b_rs1, b_rs2;
    logic [4:0]  b_rd;
    logic        e_in_ready, e_out_valid, e_rf_we, e_load, e_store, e_branch, e_jump;
    logic        e_ebreak, e_illegal;
    logic [31:0] e_pc, e_imm, e_rs1, e_rs2;
    logic [4:0]  e_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv_idu_hs #(.WIDTH(32), .NREG(32), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_pc), .out_imm(a_imm),
        .out_rs1_data(a_rs1), .out_rs2_data(a_rs2), .out_rd(a_rd), .out_rf_we(a_rf_we),
        .out_is_load(a_load), .out_is_store(a_store), .out_is_branch(a_branch),
        .out_is_jump(a_jump), .out_ebreak(a_ebreak), .out_illegal(a_illegal)
    );

    rv_idu_hs #(.WIDTH(32), .NREG(32), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_pc), .out_imm(b_imm),
        .out_rs1_data(b_rs1), .out_rs2_data(b_rs2), .out_rd(b_rd), .out_rf_we(b_rf_we),
        .out_is_load(b_load), .out_is_store(b_store), .out_is_branch(b_branch),
        .out_is_jump(b_jump), .out_ebreak(b_ebreak), .out_illegal(b_illegal)
    );

    rv_idu_hs #(.WIDTH(32), .NREG(16), .BYPASS(1'b1)) dut_e (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(e_out_valid), .out_ready(out_ready), .out_pc(e_pc), .out_imm(e_imm),
        .out_rs1_data(e_rs1), .out_rs2_data(e_rs2), .out_rd(e_rd), .out_rf_we(e_rf_we),
        .out_is_load(e_load), .out_is_store(e_store), .out_is_branch(e_branch),
        .out_is_jump(e_jump), .out_ebreak(e_ebreak), .out_illegal(e_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        step();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        in_inst = 32'd0; in_pc = 32'd0; wb_addr = 5'd0; wb_data = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid", 32'(a_out_valid), 32'd0);
        check("rst_imm", a_imm, 32'd0);
        check("rst_pc", a_pc, 32'd0);
        check("rst_rf_we", 32'(a_rf_we), 32'd0);
        check("rst_in_ready", 32'(a_in_ready), 32'd1);

        // addi x1,x0,-5
        issue(32'hFFB0_0093, 32'h100);
        in_valid = 1'b0;
        check("addi_valid", 32'(a_out_valid), 32'd1);
        check("addi_imm", a_imm, 32'hFFFF_FFFB);
        check("addi_rd", 32'(a_rd), 32'd1);
        check("addi_we", 32'(a_rf_we), 32'd1);
        check("addi_pc", a_pc, 32'h100);
        check("addi_illegal", 32'(a_illegal), 32'd0);
        step();
        check("drain_valid", 32'(a_out_valid), 32'd0);

        // Preload x1, x2, x5
        wb_en = 1'b1;
        wb_addr = 5'd1; wb_data = 32'h11; step();
        wb_addr = 5'd2; wb_data = 32'h22; step();
        wb_addr = 5'd5; wb_data = 32'h55; step();

        // add x4,x3,x0 with same-cycle write of x3
        wb_addr = 5'd3; wb_data = 32'h1234;
        issue(32'h0001_8233, 32'h140);
        wb_en = 1'b0; in_valid = 1'b0;
        check("byp1_rs1", a_rs1, 32'h1234);
        check("byp0_rs1", b_rs1, 32'h0);
        check("add_rd", 32'(a_rd), 32'd4);
        check("add_imm", a_imm, 32'd0);
        step();

        // add x6,x1,x2 then stall with a new instruction waiting
        issue(32'h0020_8333, 32'h200);
        check("bp_rs1", a_rs1, 32'h11);
        check("bp_rs2", a_rs2, 32'h22);
        out_ready = 1'b0; in_inst = 32'h0010_0393; in_pc = 32'h204;
        #1;
        check("bp_in_ready0", 32'(a_in_ready), 32'd0);
        step();
        check("bp_hold_valid", 32'(a_out_valid), 32'd1);
        check("bp_hold_pc", a_pc, 32'h200);
        check("bp_in_ready1", 32'(a_in_ready), 32'd0);
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'hABCD;
        step();
        wb_en = 1'b0;
        check("bp_refresh_rs2", a_rs2, 32'hABCD);
        check("bp_refresh_nb", b_rs2, 32'hABCD);
        check("bp_keep_rs1", a_rs1, 32'h11);
        step();
        check("bp_hold_pc2", a_pc, 32'h200);
        check("bp_hold_rd", 32'(a_rd), 32'd6);
        check("bp_in_ready2", 32'(a_in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        check("bp_next_pc", a_pc, 32'h204);
        check("bp_next_imm", a_imm, 32'd1);
        check("bp_next_rd", 32'(a_rd), 32'd7);

        // Flush with a valid held entry and an incoming lui
        flush = 1'b1; in_inst = 32'h1234_5437; in_pc = 32'h300;
        step();
        check("flush_valid", 32'(a_out_valid), 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("flush_nocap", 32'(a_out_valid), 32'd0);

        // Immediate formats and class flags
        issue(32'h1234_5437, 32'h300);
        check("lui_imm", a_imm, 32'h1234_5000);
        check("lui_we", 32'(a_rf_we), 32'd1);
        issue(32'h0020_A423, 32'h304);
        check("sw_imm", a_imm, 32'd8);
        check("sw_store", 32'(a_store), 32'd1);
        check("sw_we", 32'(a_rf_we), 32'd0);
        check("sw_rs2", a_rs2, 32'hABCD);
        issue(32'hFE00_0EE3, 32'h308);
        check("beq_imm", a_imm, 32'hFFFF_FFFC);
        check("beq_branch", 32'(a_branch), 32'd1);
        check("beq_we", 32'(a_rf_we), 32'd0);
        issue(32'h0080_006F, 32'h30C);
        check("jal_imm", a_imm, 32'd8);
        check("jal_jump", 32'(a_jump), 32'd1);
        check("jal_we", 32'(a_rf_we), 32'd0);
        issue(32'h0010_0073, 32'h310);
        check("ebreak", 32'(a_ebreak), 32'd1);
        check("ebreak_illegal", 32'(a_illegal), 32'd0);
        issue(32'h0000_007F, 32'h314);
        check("badop_illegal", 32'(a_illegal), 32'd1);
        check("badop_we", 32'(a_rf_we), 32'd0);
        check("badop_ebreak", 32'(a_ebreak), 32'd0);

        // add x17,x1,x2 on RV32E
        issue(32'h0020_88B3, 32'h318);
        check("e_illegal", 32'(e_illegal), 32'd1);
        check("e_we", 32'(e_rf_we), 32'd0);
        check("i_illegal", 32'(a_illegal), 32'd0);
        check("i_we", 32'(a_rf_we), 32'd1);

        // addi x9,x5,0 then reset while stalled
        issue(32'h0002_8493, 32'h400);
        check("pre_rst_rs1", a_rs1, 32'h55);
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", 32'(a_out_valid), 32'd0);
        check("mid_rst_pc", a_pc, 32'd0);
        check("mid_rst_ready", 32'(a_in_ready), 32'd1);
        step();
        check("mid_rst_dropped", 32'(a_out_valid), 32'd0);
        out_ready = 1'b1;
        issue(32'h0002_8493, 32'h404);
        in_valid = 1'b0;
        check("post_rst_valid", 32'(a_out_valid), 32'd1);
        check("post_rst_x5", a_rs1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_idu_hs.md
RV_IDU_HS -- requirements
Module: rv_idu_hs

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath, immediate and register width.
REQ-002 SHALL have parameter NREG, default 32: architectural register count, 32 (RV32I) or 16 (RV32E).
REQ-003 SHALL have parameter BYPASS, default 1: 1 enables writeback-to-read forwarding.
REQ-004 SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-005 clk  in  1  clock; all state updates on posedge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  upstream instruction valid.
REQ-008 in_ready  out  1  decode stage can accept an instruction.
REQ-009 in_inst  in  32  instruction word.
REQ-010 in_pc  in  WIDTH  instruction address.
REQ-011 flush  in  1  discard the held and incoming instruction.
REQ-012 wb_en, wb_addr[4:0], wb_data[WIDTH]  in  register-file write port.
REQ-013 out_valid  out  1  decoded instruction valid.
REQ-014 out_ready  in  1  downstream accepts the decoded instruction.
REQ-015 out_pc, out_imm, out_rs1_data, out_rs2_data  out  WIDTH  decoded payload.
REQ-016 out_rd  out  5  destination register; out_rf_we  out  1  rd write enable.
REQ-017 out_is_load, out_is_store, out_is_branch, out_is_jump, out_ebreak, out_illegal  out  1 each  class flags.

Function
REQ-018 SHALL hold a single-entry output register; in_ready = !out_valid | out_ready, combinationally.
REQ-019 SHALL capture the instruction on in_valid & in_ready & !flush; out_valid rises the next cycle, so latency is 1 cycle.
REQ-020 SHALL hold out_valid and the whole payload stable while out_valid & !out_ready.
REQ-021 SHALL clear out_valid at the next edge when out_ready is high and no new instruction is captured that cycle.
REQ-022 flush SHALL take priority: next cycle out_valid=0, and nothing is captured that cycle even if in_valid & in_ready.
REQ-023 SHALL generate the immediate by RV32I type: I, S, B, U, J; R-type and unknown opcodes give 0.
REQ-024 SHALL set out_rf_we=1 for R, I, U and J types with rd!=0; S and B types give 0.
REQ-025 SHALL set out_illegal=1, with out_rf_we=0, when:
  - the opcode is not one of the ten RV32I opcodes plus SYSTEM, or
  - any used rs1/rs2/rd index is >= NREG.
REQ-026 SHALL set out_ebreak=1 only for in_inst==32'h00100073.
REQ-027 Register file: NREG x WIDTH; written at posedge when wb_en & wb_addr!=0 & wb_addr<NREG. x0 always reads 0.
REQ-028 BYPASS=1: at capture, a source equal to wb_addr (nonzero, wb_en) SHALL take wb_data instead of the array value.
REQ-029 BYPASS=0: a same-cycle write SHALL NOT be visible at capture; the old array value is latched.
REQ-030 Refresh: while out_valid & !out_ready, a writeback to a held nonzero source SHALL update that operand at the edge, independent of BYPASS.
REQ-031 A used rs index >= NREG SHALL read 0.

Reset
REQ-032 On rst:
  - out_valid=0;
  - all payload outputs and flags=0;
  - all register-file entries=0.
REQ-033 rst SHALL override capture, flush and writeback in the same cycle; in_ready=1 in the first cycle after reset.
REQ-034 An instruction held when rst asserts SHALL be dropped and not presented again.

Verification
REQ-035 Basic decode: addi x1,x0,-5 (0xFFB00093), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFB, out_rd=1, out_rf_we=1.
REQ-036 Bypass: wb_en, wb_addr=3, wb_data=0x1234 in the capture cycle of add x4,x3,x0:
  - BYPASS=1 -> out_rs1_data=0x1234;
  - BYPASS=0 -> out_rs1_data=0.
REQ-037 Backpressure: out_ready=0 for 3 cycles with in_valid=1:
  - in_ready=0 for those cycles;
  - payload stable;
  - a wb to the held rs2 updates out_rs2_data.
REQ-038 Flush: flush with in_valid=1 and out_valid=1 -> next cycle out_valid=0 and the incoming instruction is not captured.
REQ-039 RV32E: NREG=16, add x17,x1,x2 -> out_illegal=1, out_rf_we=0.
REQ-040 Mid-operation reset: rst while out_valid=1 & out_ready=0 -> next cycle out_valid=0, and x5 then reads 0.
